csr_exec: RTL
=============

Name: csr_exec

Overview:
- Execute-stage unit for Zicsr instructions (CSRRW/CSRRS/CSRRC and immediate forms).
- Sits between the dispatch/issue stage and the CSR register file.
- Accepts one CSR instruction at a time over a valid/ready handshake, then reads the CSR and computes the read-modify-write value.
- Issues the write, then returns the old CSR value (or an illegal-instruction exception) to writeback.

Parameters:
- XLEN, 32, datapath width; must match the CSR file.
- EXC_ILLEGAL, 2, mcause code reported for illegal CSR access.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  pipeline flush; kills the in-flight op
- req_valid  in  1  CSR instruction valid
- req_ready  out  1  unit can accept
- req_op  in  2  01 RW, 10 RS, 11 RC, 00 reserved
- req_imm  in  1  source is zero-extended uimm instead of rs1 value
- req_uimm  in  5  immediate field
- req_rs1  in  XLEN  rs1 operand value
- req_rs1_zero  in  1  rs1 index (or uimm) is zero
- req_rd  in  5  destination register index
- req_addr  in  12  CSR address
- csr_raddr  out  12  CSR read address
- csr_rdata  in  XLEN  CSR read data; combinational from csr_raddr
- csr_ro  in  1  addressed CSR is read-only
- csr_rexc  in  1  CSR access fault
- csr_wvalid  out  1  CSR write strobe
- csr_waddr  out  12  CSR write address
- csr_wdata  out  XLEN  CSR write data
- rsp_valid  out  1  result valid
- rsp_ready  in  1  writeback accepts result
- rsp_rd  out  5  destination index
- rsp_we  out  1  write rd; 0 if rd==0 or exception
- rsp_data  out  XLEN  old CSR value (0 on exception)
- rsp_exc  out  1  exception raised
- rsp_cause  out  4  exception cause

Behaviour:
Clock and reset:
- Reset rst, synchronous, active-high; clock clk.
- Reset values: state IDLE, rsp_valid=0, csr_wvalid=0, req_ready=1, and all latched fields cleared to 0.
- rst asserted in any state aborts the op with no write.

State machine (IDLE, READ, WRITE, RESP):
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch all req_* fields and go to READ.
- READ (1 cycle):
  - csr_raddr = latched addr.
  - Capture old=csr_rdata, along with csr_ro and csr_rexc.
  - Compute src = req_imm ? {27'b0,uimm} : rs1.
  - Compute new value: RW = src; RS = old|src; RC = old&~src.
  - Write-needed: RW always (including rs1=x0); RS/RC only when rs1_zero=0.
  - Exception when csr_rexc=1 or op=00; cause=EXC_ILLEGAL and no write.
  - Next state: WRITE if write-needed and no exception and write permitted; otherwise RESP.
- WRITE (1 cycle):
  - csr_wvalid=1, csr_waddr=addr, csr_wdata=new value.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_* fields held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE.

Timing and handshake:
- req_ready=0 in READ, WRITE and RESP.
- No back-to-back acceptance: at most one op in flight.
- Latency from accept edge T:
  - rsp_valid rises at T+2 when no write is issued.
  - rsp_valid rises at T+3 when a write is issued.
  - Throughput: one op per 3 cycles minimum (4 with a write).
- csr_wvalid is strictly a one-cycle pulse per op and never repeats while in RESP under backpressure.

Flush:
- flush has priority over everything in any state.
- Next state is IDLE, rsp_valid drops, and csr_wvalid is gated to 0 in the same cycle.
- A req_valid coincident with flush in IDLE is not accepted; req_ready=0 in that cycle.

Optional Feature:
- Macro: CSR_EXEC_RO_TRAP_EN.
- Defined: a needed write to a CSR with csr_ro=1 raises an exception (rsp_exc=1, cause EXC_ILLEGAL, rsp_we=0), with no write.
- Undefined: such a write is silently dropped. No csr_wvalid is issued, rsp_exc=0, and the old value is returned to rd normally.
- Read-only access without a write (RS/RC with rs1_zero) never traps in either build.

Test Plan:
- CSRRW rd=5, addr 0x305, rs1=0x80000100 with CSR old=0 -> csr_wvalid one pulse at T+2 with wdata 0x80000100; rsp at T+3 with rd=5, data=0, we=1.
- CSRRS rs1_zero=1, addr 0x342, old=0xB -> no csr_wvalid; rsp at T+2 with data=0xB; CSRRC uimm=3, old=0xF -> wdata=0xC.
- CSRRW to 0xF11 (csr_ro=1) -> with CSR_EXEC_RO_TRAP_EN: rsp_exc=1, cause=2, no write; without the macro: no write, rsp_exc=0, data=old.
- Write-path op with rsp_ready held low 5 cycles -> rsp fields stable, exactly one csr_wvalid pulse, req_ready=0 until handshake.
- flush asserted in WRITE state -> csr_wvalid=0 that cycle, no rsp_valid, req_ready=1 next cycle; same check for rst asserted mid-op.
- op=00 or csr_rexc=1 -> rsp_exc=1, cause=2, rsp_we=0, rsp_data=0, no write.

Source files
------------

// File: rtl/csr_exec.sv
// Zicsr execute unit: accepts one CSR instruction, reads the CSR, issues the
// read-modify-write, then returns the old value. Optional macro: CSR_EXEC_RO_TRAP_EN.
module csr_exec #(
    parameter int XLEN        = 32,
    parameter int EXC_ILLEGAL = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic            req_imm,
    input  logic [4:0]      req_uimm,
    input  logic [XLEN-1:0] req_rs1,
    input  logic            req_rs1_zero,
    input  logic [4:0]      req_rd,
    input  logic [11:0]     req_addr,
    output logic [11:0]     csr_raddr,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic            csr_ro,
    input  logic            csr_rexc,
    output logic            csr_wvalid,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [4:0]      rsp_rd,
    output logic            rsp_we,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_exc,
    output logic [3:0]      rsp_cause
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready
    // are both high; valid and payload stay stable until that edge.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'(EXC_ILLEGAL);

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic              imm_q, imm_d;
    logic [4:0]        uimm_q, uimm_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic              rs1_zero_q, rs1_zero_d;
    logic [4:0]        rd_q, rd_d;
    logic [11:0]       addr_q, addr_d;
    logic [XLEN-1:0]   old_q, old_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              exc_q, exc_d;

    logic [XLEN-1:0]   src;
    logic [XLEN-1:0]   new_val;
    logic              write_need;
    logic              exc_now;
    logic              write_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= 2'b00;
            imm_q      <= 1'b0;
            uimm_q     <= 5'd0;
            rs1_q      <= '0;
            rs1_zero_q <= 1'b0;
            rd_q       <= 5'd0;
            addr_q     <= 12'd0;
            old_q      <= '0;
            wdata_q    <= '0;
            exc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            imm_q      <= imm_d;
            uimm_q     <= uimm_d;
            rs1_q      <= rs1_d;
            rs1_zero_q <= rs1_zero_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            old_q      <= old_d;
            wdata_q    <= wdata_d;
            exc_q      <= exc_d;
        end
    end

    // Read-modify-write datapath, meaningful only while in READ.
    always_comb begin
        src = imm_q ? {{(XLEN-5){1'b0}}, uimm_q} : rs1_q;
        case (op_q)
            2'b01:   new_val = src;
            2'b10:   new_val = csr_rdata | src;
            2'b11:   new_val = csr_rdata & ~src;
            default: new_val = src;
        endcase
        write_need = (op_q == 2'b01) || ((op_q != 2'b00) && !rs1_zero_q);
`ifdef CSR_EXEC_RO_TRAP_EN
        exc_now = csr_rexc || (op_q == 2'b00) || (write_need && csr_ro);
`else
        exc_now = csr_rexc || (op_q == 2'b00);
`endif
        write_ok = write_need && !exc_now && !csr_ro;
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        imm_d      = imm_q;
        uimm_d     = uimm_q;
        rs1_d      = rs1_q;
        rs1_zero_d = rs1_zero_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        old_d      = old_q;
        wdata_d    = wdata_q;
        exc_d      = exc_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d       = req_op;
                    imm_d      = req_imm;
                    uimm_d     = req_uimm;
                    rs1_d      = req_rs1;
                    rs1_zero_d = req_rs1_zero;
                    rd_d       = req_rd;
                    addr_d     = req_addr;
                    state_d    = READ;
                end
            end
            READ: begin
                old_d   = exc_now ? '0 : csr_rdata;
                wdata_d = new_val;
                exc_d   = exc_now;
                state_d = write_ok ? WRITE : RESP;
            end
            WRITE: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A flush kills whatever is in flight, including a same-cycle accept.
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        req_ready  = (state_q == IDLE) && !flush;
        csr_raddr  = addr_q;
        csr_wvalid = (state_q == WRITE) && !flush && !rst;
        csr_waddr  = addr_q;
        csr_wdata  = wdata_q;
        rsp_valid  = (state_q == RESP) && !flush && !rst;
        rsp_rd     = rd_q;
        rsp_we     = (rd_q != 5'd0) && !exc_q;
        rsp_data   = old_q;
        rsp_exc    = exc_q;
        rsp_cause  = exc_q ? CAUSE_ILLEGAL : 4'd0;
    end

endmodule
